// File: rtl/cdb_arbiter.sv
// cdb_arbiter: Common Data Bus stage of the Tomasulo RV32 core.
// Holds one finished result per functional unit. Each cycle it grants the
// single CDB slot round-robin and broadcasts one (tag, value) pair to the
// reservation stations and the register result status table.
// Tag 0 means "no producer" and is never broadcast.

module cdb_arbiter #(
    parameter int MAX_FU_NUM = 10,
    parameter int Q_WIDTH    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [MAX_FU_NUM-1:0]     fu_valid,
    input  logic [32*MAX_FU_NUM-1:0]  fu_data,
    output logic [MAX_FU_NUM-1:0]     fu_ready,
    input  logic                      flush,
    output logic                      cdb_valid,
    output logic [Q_WIDTH-1:0]        cdb_tag,
    output logic [31:0]               cdb_data,
    output logic [31:0]               cdb_count
);

    localparam int                  NUM_ENT  = MAX_FU_NUM - 1;
    localparam logic [Q_WIDTH-1:0]  LAST_TAG = Q_WIDTH'(MAX_FU_NUM - 1);
    localparam logic [Q_WIDTH:0]    ENT_WIDE = (Q_WIDTH+1)'(MAX_FU_NUM - 1);

    // Holding entries. Slot 0 is never written, so it stays empty and zero.
    logic [MAX_FU_NUM-1:0]  buf_full_q;
    logic [MAX_FU_NUM-1:0]  buf_full_d;
    logic [31:0]            buf_data_q [MAX_FU_NUM];
    logic [31:0]            buf_data_d [MAX_FU_NUM];

    // Round-robin pointer: the tag granted most recently.
    logic [Q_WIDTH-1:0]     rr_ptr_q;
    logic [Q_WIDTH-1:0]     rr_ptr_d;

    // Registered broadcast outputs.
    logic                   cdb_valid_q;
    logic                   cdb_valid_d;
    logic [Q_WIDTH-1:0]     cdb_tag_q;
    logic [Q_WIDTH-1:0]     cdb_tag_d;
    logic [31:0]            cdb_data_q;
    logic [31:0]            cdb_data_d;
    logic [31:0]            cdb_count_q;
    logic [31:0]            cdb_count_d;

    // Arbitration and handshake signals.
    logic [MAX_FU_NUM-1:0]  grant_s;
    logic [Q_WIDTH-1:0]     grant_tag_s;
    logic                   grant_any_s;
    logic [MAX_FU_NUM-1:0]  fu_ready_s;
    logic [MAX_FU_NUM-1:0]  hs_s;

    // Scan temporaries of the grant search.
    logic                   found_v;
    logic [Q_WIDTH:0]       sum_v;
    logic [Q_WIDTH-1:0]     idx_v;

    // Slot 0 carries no result; its data lane and handshake bit are dropped.
    logic                   unused_s;
    assign unused_s = ^{fu_data[31:0], hs_s[0]};

    // Round-robin search: start after rr_ptr, wrap from the last tag to 1, first full entry wins.
    always_comb begin
        grant_s     = '0;
        grant_tag_s = '0;
        found_v     = 1'b0;
        sum_v       = '0;
        idx_v       = '0;
        for (int k = 1; k <= NUM_ENT; k++) begin
            sum_v = {1'b0, rr_ptr_q} + (Q_WIDTH+1)'(k);
            if (sum_v > ENT_WIDE) begin
                idx_v = Q_WIDTH'(sum_v - ENT_WIDE);
            end else begin
                idx_v = sum_v[Q_WIDTH-1:0];
            end
            if (!found_v && buf_full_q[idx_v]) begin
                found_v        = 1'b1;
                grant_s[idx_v] = 1'b1;
                grant_tag_s    = idx_v;
            end else begin
                found_v = found_v;
            end
        end
    end

    assign grant_any_s = |grant_s;

    // Accept when the entry is empty or drains this cycle; nothing is accepted during a flush.
    always_comb begin
        fu_ready_s = '0;
        if (flush) begin
            fu_ready_s = '0;
        end else begin
            fu_ready_s    = ~buf_full_q | grant_s;
            fu_ready_s[0] = 1'b0;
        end
    end

    assign fu_ready = fu_ready_s;
    assign hs_s     = fu_valid & fu_ready_s;

    // Next state: broadcast the granted entry, then let a same-cycle capture refill it.
    always_comb begin
        buf_full_d  = buf_full_q;
        buf_data_d  = buf_data_q;
        rr_ptr_d    = rr_ptr_q;
        cdb_valid_d = 1'b0;
        cdb_tag_d   = '0;
        cdb_data_d  = 32'h0000_0000;
        cdb_count_d = cdb_count_q;
        if (flush) begin
            buf_full_d = '0;
        end else begin
            if (grant_any_s) begin
                cdb_valid_d = 1'b1;
                cdb_tag_d   = grant_tag_s;
                cdb_data_d  = buf_data_q[grant_tag_s];
                rr_ptr_d    = grant_tag_s;
                cdb_count_d = cdb_count_q + 32'd1;
            end else begin
                rr_ptr_d = rr_ptr_q;
            end
            for (int i = 1; i < MAX_FU_NUM; i++) begin
                if (hs_s[i]) begin
                    buf_full_d[i] = 1'b1;
                    buf_data_d[i] = fu_data[32*i +: 32];
                end else if (grant_s[i]) begin
                    buf_full_d[i] = 1'b0;
                end else begin
                    buf_full_d[i] = buf_full_q[i];
                end
            end
        end
    end

    // State registers with synchronous reset; the pointer resets so the first search begins at tag 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_full_q  <= '0;
            for (int i = 0; i < MAX_FU_NUM; i++) begin
                buf_data_q[i] <= 32'h0000_0000;
            end
            rr_ptr_q    <= LAST_TAG;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= 32'h0000_0000;
            cdb_count_q <= 32'h0000_0000;
        end else begin
            buf_full_q  <= buf_full_d;
            buf_data_q  <= buf_data_d;
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_data_q  <= cdb_data_d;
            cdb_count_q <= cdb_count_d;
        end
    end

    assign cdb_valid = cdb_valid_q;
    assign cdb_tag   = cdb_tag_q;
    assign cdb_data  = cdb_data_q;
    assign cdb_count = cdb_count_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios with literal
// expectations, then randomized traffic checked cycle by cycle against a
// behavioural model of the holding entries and round-robin grant.

module tb_cdb_arbiter;

    localparam int NF = 10;
    localparam int NE = NF - 1;

    logic              clk;
    logic              rst;
    logic [NF-1:0]     fu_valid;
    logic [32*NF-1:0]  fu_data;
    logic [NF-1:0]     fu_ready;
    logic              flush;
    logic              cdb_valid;
    logic [3:0]        cdb_tag;
    logic [31:0]       cdb_data;
    logic [31:0]       cdb_count;

    cdb_arbiter #(.MAX_FU_NUM(NF), .Q_WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .fu_valid  (fu_valid),
        .fu_data   (fu_data),
        .fu_ready  (fu_ready),
        .flush     (flush),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .cdb_count (cdb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: which FUs hold a result, their values, last winner.
    bit          m_full [NF];
    logic [31:0] m_data [NF];
    int          m_last;
    bit          m_cv;
    int          m_tag;
    logic [31:0] m_cd;
    logic [31:0] m_cnt;
    bit [NF-1:0] m_hs;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Next winner: first FU holding a result, looking at the FUs after the last winner in circular order.
    function automatic int model_winner();
        for (int k = 1; k <= NE; k++) begin
            int t;
            t = ((m_last + k - 1) % NE) + 1;
            if (m_full[t]) return t;
        end
        return 0;
    endfunction

    function automatic logic [32*NF-1:0] put(input logic [32*NF-1:0] d, input int i, input logic [31:0] x);
        d[32*i +: 32] = x;
        return d;
    endfunction

    // One clock cycle: drive inputs, check fu_ready, advance the model, check the CDB outputs.
    task automatic cycle(input logic [NF-1:0] v, input logic [32*NF-1:0] d, input bit fl, input bit r);
        int w;
        logic [NF-1:0] exp_rdy;
        fu_valid = v;
        fu_data  = d;
        flush    = fl;
        rst      = r;
        #1;
        w = model_winner();
        exp_rdy = '0;
        if (!fl) begin
            for (int i = 1; i < NF; i++) exp_rdy[i] = !m_full[i] || (i == w);
        end
        if (!r) chk("fu_ready", fu_ready, exp_rdy);
        m_hs = '0;
        if (r) begin
            for (int i = 0; i < NF; i++) begin m_full[i] = 0; m_data[i] = 0; end
            m_last = NE; m_cv = 0; m_tag = 0; m_cd = 0; m_cnt = 0;
        end else if (fl) begin
            for (int i = 0; i < NF; i++) m_full[i] = 0;
            m_cv = 0; m_tag = 0; m_cd = 0;
        end else begin
            if (w != 0) begin
                m_cv = 1; m_tag = w; m_cd = m_data[w];
                m_full[w] = 0; m_last = w; m_cnt = m_cnt + 32'd1;
            end else begin
                m_cv = 0; m_tag = 0; m_cd = 0;
            end
            m_hs = v & exp_rdy;
            for (int i = 1; i < NF; i++) begin
                if (m_hs[i]) begin m_full[i] = 1; m_data[i] = d[32*i +: 32]; end
            end
        end
        @(posedge clk);
        #1;
        chk("cdb_valid", cdb_valid, m_cv);
        chk("cdb_tag", cdb_tag, 64'(m_tag));
        chk("cdb_data", cdb_data, m_cd);
        chk("cdb_count", cdb_count, m_cnt);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle('0, '0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        cycle('0, '0, 1'b0, 1'b1);
        cycle('0, '0, 1'b0, 1'b1);
    endtask

    logic [32*NF-1:0] dd;
    bit   [NF-1:0]    pend;
    logic [31:0]      pdata [NF];
    logic [NF-1:0]    rv;
    logic [31:0]      cnt_before;

    initial begin
        fu_valid = '0; fu_data = '0; flush = 1'b0; rst = 1'b1;

        // Reset state
        do_reset();
        chk("rst_valid", cdb_valid, 1'b0);
        chk("rst_count", cdb_count, 32'd0);
        chk("rst_ready", fu_ready, 10'h3FE);

        // Single result from FU 3
        dd = put('0, 3, 32'h0000_002A);
        cycle(10'b00_0000_1000, dd, 1'b0, 1'b0);
        chk("single_lat", cdb_valid, 1'b0);
        idle(1);
        chk("single_valid", cdb_valid, 1'b1);
        chk("single_tag", cdb_tag, 4'd3);
        chk("single_data", cdb_data, 32'h2A);
        chk("single_count", cdb_count, 32'd1);
        idle(1);
        chk("single_once", cdb_valid, 1'b0);

        // Simultaneous capture of FUs 2, 5, 9
        do_reset();
        dd = put('0, 2, 32'h22); dd = put(dd, 5, 32'h55); dd = put(dd, 9, 32'h99);
        cycle(10'b10_0010_0100, dd, 1'b0, 1'b0);
        idle(1); chk("sim_tag0", cdb_tag, 4'd2); chk("sim_data0", cdb_data, 32'h22);
        idle(1); chk("sim_tag1", cdb_tag, 4'd5); chk("sim_data1", cdb_data, 32'h55);
        idle(1); chk("sim_tag2", cdb_tag, 4'd9); chk("sim_data2", cdb_data, 32'h99);
        chk("sim_count", cdb_count, 32'd3);

        // Round-robin wrap with every FU continuously valid
        do_reset();
        dd = '0;
        for (int i = 1; i < NF; i++) dd = put(dd, i, 32'h100 + 32'(i));
        cycle(10'h3FE, dd, 1'b0, 1'b0);
        for (int j = 0; j < 18; j++) begin
            cycle(10'h3FE, dd, 1'b0, 1'b0);
            chk("rr_tag", cdb_tag, 64'((j % 9) + 1));
        end

        // Backpressure on FU 4 and same-cycle refill
        do_reset();
        dd = put('0, 1, 32'h11); dd = put(dd, 2, 32'h22); dd = put(dd, 3, 32'h33); dd = put(dd, 4, 32'h04);
        cycle(10'b00_0001_1110, dd, 1'b0, 1'b0);
        chk("bp_rdy0", fu_ready[4], 1'b0);
        dd = put('0, 4, 32'h44);
        cycle(10'b00_0001_0000, dd, 1'b0, 1'b0);
        chk("bp_rdy1", fu_ready[4], 1'b0);
        chk("bp_tag1", cdb_tag, 4'd1);
        cycle(10'b00_0001_0000, dd, 1'b0, 1'b0);
        chk("bp_rdy2", fu_ready[4], 1'b0);
        cycle(10'b00_0001_0000, dd, 1'b0, 1'b0);
        chk("bp_rdy3", fu_ready[4], 1'b1);
        cycle(10'b00_0001_0000, dd, 1'b0, 1'b0);
        chk("bp_old_tag", cdb_tag, 4'd4);
        chk("bp_old_data", cdb_data, 32'h04);
        idle(1);
        chk("bp_new_tag", cdb_tag, 4'd4);
        chk("bp_new_data", cdb_data, 32'h44);
        chk("bp_count", cdb_count, 32'd5);

        // Flush discards FUs 1 and 6
        do_reset();
        dd = put('0, 1, 32'hAAAA_0001); dd = put(dd, 6, 32'hAAAA_0006);
        cycle(10'b00_0100_0010, dd, 1'b0, 1'b0);
        cnt_before = m_cnt;
        cycle('0, '0, 1'b1, 1'b0);
        chk("flush_valid", cdb_valid, 1'b0);
        chk("flush_count", cdb_count, cnt_before);
        for (int j = 0; j < 4; j++) begin
            idle(1);
            chk("flush_quiet", cdb_valid, 1'b0);
        end

        // Reset mid-operation with three entries full
        dd = put('0, 3, 32'h3); dd = put(dd, 5, 32'h5); dd = put(dd, 7, 32'h7);
        cycle(10'b00_1010_1000, dd, 1'b0, 1'b0);
        cycle('0, '0, 1'b0, 1'b1);
        chk("mrst_valid", cdb_valid, 1'b0);
        chk("mrst_tag", cdb_tag, 4'd0);
        chk("mrst_data", cdb_data, 32'd0);
        chk("mrst_count", cdb_count, 32'd0);
        chk("mrst_ready", fu_ready, 10'h3FE);
        dd = put('0, 9, 32'h9); dd = put(dd, 1, 32'h1);
        cycle(10'b10_0000_0010, dd, 1'b0, 1'b0);
        idle(1);
        chk("mrst_first", cdb_tag, 4'd1);
        idle(3);

        // Randomized traffic: FUs hold valid and data until accepted
        do_reset();
        pend = '0;
        for (int c = 0; c < 3000; c++) begin
            rv = '0;
            dd = '0;
            for (int i = 1; i < NF; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i]  = 1'b1;
                    pdata[i] = $urandom;
                end
                rv[i] = pend[i];
                dd = put(dd, i, pend[i] ? pdata[i] : $urandom);
            end
            rv[0] = 1'($urandom_range(0, 1));
            dd = put(dd, 0, $urandom);
            cycle(rv, dd, $urandom_range(0, 63) == 0, $urandom_range(0, 499) == 0);
            pend = pend & ~m_hs;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
